// File: rtl/float_to_int_cvt.sv
// float_to_int_cvt: multi-cycle IEEE-754 single-precision to IW-bit integer
// converter. One request in flight; the mantissa is aligned by a serial
// right shifter that collects guard/sticky bits, then rounded and saturated.
module float_to_int_cvt #(
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   input_a,
  input  logic [2:0]    rm,
  input  logic          is_signed,
  output logic [IW-1:0] output_z,
  output logic          output_z_stb,
  input  logic          out_ready,
  output logic          flag_nv,
  output logic          flag_nx
);

  typedef enum logic [2:0] {IDLE, SPECIAL, SHIFT, ROUND, PUT} state_t;

  state_t        r_state, w_next;

  logic [31:0]   r_a;
  logic [2:0]    r_rm;
  logic          r_sgn_mode;
  logic [IW:0]   r_mag;
  logic          r_g, r_s;
  logic [9:0]    r_cnt;
  logic [IW-1:0] r_z;
  logic          r_nv, r_nx;

  // Rounding increment from mode, operand sign, guard, sticky and result lsb.
  function automatic logic round_inc(input logic [2:0] mode, input logic sign,
                                     input logic g, input logic s, input logic lsb);
    case (mode)
      3'b001:  round_inc = 1'b0;
      3'b010:  round_inc = sign & (g | s);
      3'b011:  round_inc = ~sign & (g | s);
      3'b100:  round_inc = g;
      default: round_inc = g & (s | lsb);
    endcase
  endfunction

  // Operand decode of the captured request.
  logic          w_sign;
  logic [7:0]    w_exp;
  logic [9:0]    w_exp_i;
  logic [22:0]   w_frac;
  logic          w_is_nan, w_is_inf, w_is_zero, w_ovf, w_terminal, w_in_range;
  logic [9:0]    w_k;
  logic [IW:0]   w_mag_init;
  logic [IW-1:0] w_max, w_negsat;

  assign w_sign     = r_a[31];
  assign w_exp      = r_a[30:23];
  assign w_exp_i    = {2'b00, w_exp};
  assign w_frac     = r_a[22:0];
  assign w_is_nan   = (w_exp == 8'hFF) && (w_frac != 23'd0);
  assign w_is_inf   = (w_exp == 8'hFF) && (w_frac == 23'd0);
  assign w_is_zero  = (w_exp == 8'h00) && (w_frac == 23'd0);
  assign w_ovf      = w_exp_i >= 10'(127 + IW);
  assign w_terminal = (w_exp == 8'hFF) || w_is_zero || w_ovf;
  assign w_in_range = w_exp >= 8'd126;
  assign w_k        = w_in_range ? (10'(IW + 126) - w_exp_i) : 10'd0;
  assign w_mag_init = {1'b0, 1'b1, w_frac, {(IW-24){1'b0}}};
  assign w_max      = r_sgn_mode ? {1'b0, {(IW-1){1'b1}}} : {IW{1'b1}};
  assign w_negsat   = r_sgn_mode ? {1'b1, {(IW-1){1'b0}}} : {IW{1'b0}};

  // Result and flags for operands resolved without shifting.
  logic [IW-1:0] w_spec_z;
  logic          w_spec_nv;
  always_comb begin
    w_spec_z  = '0;
    w_spec_nv = 1'b0;
    if (w_is_nan || (w_is_inf && !w_sign)) begin
      w_spec_z  = w_max;
      w_spec_nv = 1'b1;
    end else if (w_is_inf) begin
      w_spec_z  = w_negsat;
      w_spec_nv = 1'b1;
    end else if (w_is_zero) begin
      w_spec_z  = '0;
    end else if (w_ovf) begin
      w_spec_z  = w_sign ? w_negsat : w_max;
      w_spec_nv = 1'b1;
    end
  end

  // Rounding, sign application and saturation of the aligned magnitude.
  logic          w_inc, w_inexact;
  logic [IW:0]   w_rmag;
  logic [IW-1:0] w_rnd_z;
  logic          w_rnd_nv, w_rnd_nx;
  always_comb begin
    w_inc     = round_inc(r_rm, w_sign, r_g, r_s, r_mag[0]);
    w_rmag    = r_mag + {{IW{1'b0}}, w_inc};
    w_inexact = r_g | r_s;
    w_rnd_z   = w_rmag[IW-1:0];
    w_rnd_nv  = 1'b0;
    w_rnd_nx  = w_inexact;
    if (r_sgn_mode) begin
      if (!w_sign) begin
        if (w_rmag > {2'b00, {(IW-1){1'b1}}}) begin
          w_rnd_z  = {1'b0, {(IW-1){1'b1}}};
          w_rnd_nv = 1'b1;
          w_rnd_nx = 1'b0;
        end
      end else if (w_rmag > {2'b01, {(IW-1){1'b0}}}) begin
        w_rnd_z  = {1'b1, {(IW-1){1'b0}}};
        w_rnd_nv = 1'b1;
        w_rnd_nx = 1'b0;
      end else begin
        w_rnd_z  = ~w_rmag[IW-1:0] + IW'(1);
      end
    end else if (w_sign) begin
      w_rnd_z = '0;
      if (w_rmag != '0) begin
        w_rnd_nv = 1'b1;
        w_rnd_nx = 1'b0;
      end
    end else if (w_rmag[IW]) begin
      w_rnd_z  = {IW{1'b1}};
      w_rnd_nv = 1'b1;
      w_rnd_nx = 1'b0;
    end
  end

  // Next-state logic of the conversion sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = SPECIAL;
      SPECIAL: begin
        if (w_terminal)        w_next = PUT;
        else if (w_k == 10'd0) w_next = ROUND;
        else                   w_next = SHIFT;
      end
      SHIFT:   if (r_cnt == 10'd1) w_next = ROUND;
      ROUND:   w_next = PUT;
      PUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; reset overrides any accept or consume.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Capture, alignment load and serial shift with guard/sticky collection.
  always_ff @(posedge clk) begin
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          r_a        <= input_a;
          r_rm       <= rm;
          r_sgn_mode <= is_signed;
        end
      end
      SPECIAL: begin
        if (w_in_range) begin
          r_mag <= w_mag_init;
          r_g   <= 1'b0;
          r_s   <= 1'b0;
        end else begin
          r_mag <= '0;
          r_g   <= 1'b0;
          r_s   <= 1'b1;
        end
        r_cnt <= w_k;
      end
      SHIFT: begin
        r_mag <= r_mag >> 1;
        r_g   <= r_mag[0];
        r_s   <= r_s | r_g;
        r_cnt <= r_cnt - 10'd1;
      end
      default: ;
    endcase
  end

  // Result registers, loaded once per operation and held through PUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z  <= '0;
      r_nv <= 1'b0;
      r_nx <= 1'b0;
    end else if (r_state == SPECIAL && w_terminal) begin
      r_z  <= w_spec_z;
      r_nv <= w_spec_nv;
      r_nx <= 1'b0;
    end else if (r_state == ROUND) begin
      r_z  <= w_rnd_z;
      r_nv <= w_rnd_nv;
      r_nx <= w_rnd_nx;
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign output_z_stb = (r_state == PUT);
  assign output_z     = r_z;
  assign flag_nv      = r_nv;
  assign flag_nx      = r_nx;

endmodule

// File: tb/tb_float_to_int_cvt.sv
// Testbench for float_to_int_cvt (IW=32): directed values, randomized
// operands against a value-level reference model, handshake and reset.
module tb_float_to_int_cvt;
  localparam int IW = 32;
  localparam logic [IW-1:0] MAXS = {1'b0, {(IW-1){1'b1}}};
  localparam logic [IW-1:0] MINS = {1'b1, {(IW-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   input_a = '0;
  logic [2:0]    rm = '0;
  logic          is_signed = 1'b0;
  logic [IW-1:0] output_z;
  logic          output_z_stb;
  logic          out_ready = 1'b0;
  logic          flag_nv, flag_nx;

  int n_pass = 0;
  int n_total = 0;

  float_to_int_cvt #(.IW(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .rm(rm), .is_signed(is_signed), .output_z(output_z),
    .output_z_stb(output_z_stb), .out_ready(out_ready),
    .flag_nv(flag_nv), .flag_nx(flag_nx)
  );

  always #5 clk = ~clk;

  // Reference: exact value as fixed point with 64 fraction bits, rounded to
  // an integer by mode, then range-checked against the target type.
  function automatic void ref_model(input logic [31:0] a, input logic [2:0] mode,
                                    input logic sgn, output logic [IW-1:0] z,
                                    output logic nv, output logic nx, output int lat);
    logic neg, inexact, up;
    int e;
    logic [159:0] f;
    logic [95:0] ip, m;
    logic [63:0] fr;
    logic [2:0] md;
    neg = a[31];
    e = int'(a[30:23]) - 127;
    md = (mode > 3'd4) ? 3'd0 : mode;
    z = '0; nv = 1'b0; nx = 1'b0; lat = 2;
    if (a[30:23] == 8'hFF) begin
      nv = 1'b1;
      if (a[22:0] != 0 || !neg) z = sgn ? MAXS : '1;
      else                      z = sgn ? MINS : '0;
      return;
    end
    if (a[30:0] == 0) return;
    if (e >= IW) begin
      nv = 1'b1;
      z = neg ? (sgn ? MINS : '0) : (sgn ? MAXS : '1);
      return;
    end
    if (a[30:23] == 0 || e < -1) begin
      ip = '0;
      fr = 64'd1;
      lat = 3;
    end else begin
      f = {136'd0, 1'b1, a[22:0]} << (e + 41);
      ip = f[159:64];
      fr = f[63:0];
      lat = 3 + (IW - 1 - e);
    end
    inexact = (fr != 0);
    case (md)
      3'd1:    up = 1'b0;
      3'd2:    up = neg && inexact;
      3'd3:    up = !neg && inexact;
      3'd4:    up = fr >= 64'h8000_0000_0000_0000;
      default: up = (fr > 64'h8000_0000_0000_0000) ||
                    (fr == 64'h8000_0000_0000_0000 && ip[0]);
    endcase
    m = ip + {95'd0, up};
    if (sgn) begin
      if (!neg && m > 96'(MAXS))                    begin z = MAXS; nv = 1'b1; end
      else if (neg && m > (96'd1 << (IW - 1)))      begin z = MINS; nv = 1'b1; end
      else begin
        z = neg ? (IW'(0) - m[IW-1:0]) : m[IW-1:0];
        nx = inexact;
      end
    end else begin
      if (neg && m != 0)                begin z = '0; nv = 1'b1; end
      else if (m >= (96'd1 << IW))      begin z = '1; nv = 1'b1; end
      else begin z = neg ? '0 : m[IW-1:0]; nx = inexact; end
    end
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [2:0] mode, input logic sgn);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    input_a = a; rm = mode; is_signed = sgn; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_stb(output int lat);
    lat = 1;
    while (lat < 200) begin
      @(posedge clk);
      #1 lat++;
      if (output_z_stb) break;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (output_z_stb !== 1'b0) $display("FAIL reset_stb got %0b want 0", output_z_stb); else n_pass++;
    n_total++; if (output_z !== '0) $display("FAIL reset_z got %h want 0", output_z); else n_pass++;
    n_total++; if ({flag_nv, flag_nx} !== 2'b00) $display("FAIL reset_flags got %b want 00", {flag_nv, flag_nx}); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", in_ready); else n_pass++;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] a; logic [2:0] rm; logic sgn; logic [31:0] z; logic nv; logic nx;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    logic [IW-1:0] mz; logic mnv, mnx; int mlat, lat;
    logic [IW-1:0] gz; logic gnv, gnx;
    v.push_back(vec_t'{32'h40200000, 3'd0, 1'b1, 32'h00000002, 1'b0, 1'b1});
    v.push_back(vec_t'{32'h40200000, 3'd4, 1'b1, 32'h00000003, 1'b0, 1'b1});
    v.push_back(vec_t'{32'h40200000, 3'd3, 1'b1, 32'h00000003, 1'b0, 1'b1});
    v.push_back(vec_t'{32'h40200000, 3'd1, 1'b1, 32'h00000002, 1'b0, 1'b1});
    v.push_back(vec_t'{32'h40200000, 3'd7, 1'b1, 32'h00000002, 1'b0, 1'b1});
    v.push_back(vec_t'{32'hBFC00000, 3'd0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1});
    v.push_back(vec_t'{32'hBFC00000, 3'd1, 1'b0, 32'h00000000, 1'b1, 1'b0});
    v.push_back(vec_t'{32'h4F000000, 3'd0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0});
    v.push_back(vec_t'{32'h4F000000, 3'd0, 1'b0, 32'h80000000, 1'b0, 1'b0});
    v.push_back(vec_t'{32'h7FC00000, 3'd0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0});
    v.push_back(vec_t'{32'h7FC00000, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
    v.push_back(vec_t'{32'hFF800000, 3'd0, 1'b1, 32'h80000000, 1'b1, 1'b0});
    v.push_back(vec_t'{32'hBE800000, 3'd1, 1'b0, 32'h00000000, 1'b0, 1'b1});
    v.push_back(vec_t'{32'hBE800000, 3'd2, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1});
    v.push_back(vec_t'{32'hCF000000, 3'd0, 1'b1, 32'h80000000, 1'b0, 1'b0});
    v.push_back(vec_t'{32'h80000000, 3'd0, 1'b1, 32'h00000000, 1'b0, 1'b0});
    v.push_back(vec_t'{32'h4F800000, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
    v.push_back(vec_t'{32'h00000001, 3'd3, 1'b0, 32'h00000001, 1'b0, 1'b1});
    foreach (v[i]) begin
      ref_model(v[i].a, v[i].rm, v[i].sgn, mz, mnv, mnx, mlat);
      start_op(v[i].a, v[i].rm, v[i].sgn);
      wait_stb(lat);
      gz = output_z; gnv = flag_nv; gnx = flag_nx;
      consume();
      n_total++; if (gz !== v[i].z) $display("FAIL dir%0d_z a=%h got %h want %h", i, v[i].a, gz, v[i].z); else n_pass++;
      n_total++; if ({gnv, gnx} !== {v[i].nv, v[i].nx}) $display("FAIL dir%0d_flags a=%h got nv,nx=%b want %b", i, v[i].a, {gnv, gnx}, {v[i].nv, v[i].nx}); else n_pass++;
      n_total++; if (lat !== mlat) $display("FAIL dir%0d_lat a=%h got %0d want %0d", i, v[i].a, lat, mlat); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a; logic [2:0] mode; logic sgn;
    logic [IW-1:0] mz; logic mnv, mnx; int mlat, lat;
    logic [IW-1:0] gz; logic gnv, gnx;
    for (int i = 0; i < 250; i++) begin
      a[31] = 1'($urandom_range(0, 1));
      a[30:23] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(120, 162));
      a[22:0] = ($urandom_range(0, 4) == 0) ? 23'($urandom_range(0, 3) << 20) : 23'($urandom);
      mode = 3'($urandom_range(0, 7));
      sgn = 1'($urandom_range(0, 1));
      ref_model(a, mode, sgn, mz, mnv, mnx, mlat);
      start_op(a, mode, sgn);
      wait_stb(lat);
      gz = output_z; gnv = flag_nv; gnx = flag_nx;
      consume();
      n_total++; if (gz !== mz) $display("FAIL rnd%0d_z a=%h rm=%0d s=%0b got %h want %h", i, a, mode, sgn, gz, mz); else n_pass++;
      n_total++; if ({gnv, gnx} !== {mnv, mnx}) $display("FAIL rnd%0d_flags a=%h rm=%0d s=%0b got %b want %b", i, a, mode, sgn, {gnv, gnx}, {mnv, mnx}); else n_pass++;
      n_total++; if (lat !== mlat) $display("FAIL rnd%0d_lat a=%h got %0d want %0d", i, a, lat, mlat); else n_pass++;
    end
  endtask

  task automatic test_handshake();
    int lat;
    start_op(32'h3F800000, 3'd0, 1'b1);
    wait_stb(lat);
    n_total++; if (lat !== 34) $display("FAIL hs_lat got %0d want 34", lat); else n_pass++;
    input_a = 32'h42F60000; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_total++; if (output_z_stb !== 1'b1) $display("FAIL hs_hold%0d_stb got %0b want 1", c, output_z_stb); else n_pass++;
      n_total++; if (output_z !== 32'h00000001) $display("FAIL hs_hold%0d_z got %h want 00000001", c, output_z); else n_pass++;
      n_total++; if ({flag_nv, flag_nx} !== 2'b00) $display("FAIL hs_hold%0d_flags got %b want 00", c, {flag_nv, flag_nx}); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL hs_hold%0d_ready got %0b want 0", c, in_ready); else n_pass++;
    end
    consume();
    in_valid = 1'b0;
    n_total++; if (output_z_stb !== 1'b0) $display("FAIL hs_after_stb got %0b want 0", output_z_stb); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL hs_no_accept_on_consume got in_ready=%0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    start_op(32'h3F800000, 3'd0, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_total++; if (output_z_stb !== 1'b0) $display("FAIL rstmid_stb got %0b want 0", output_z_stb); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got %0b want 1", in_ready); else n_pass++;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 if (output_z_stb) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL rstmid_aborted_result got %0d stb cycles want 0", seen); else n_pass++;
    start_op(32'h42F60000, 3'd0, 1'b1);
    wait_stb(lat);
    n_total++; if (output_z !== 32'h0000007B) $display("FAIL rstmid_next_z got %h want 0000007b", output_z); else n_pass++;
    n_total++; if ({flag_nv, flag_nx} !== 2'b00) $display("FAIL rstmid_next_flags got %b want 00", {flag_nv, flag_nx}); else n_pass++;
    n_total++; if (lat !== 28) $display("FAIL rstmid_next_lat got %0d want 28", lat); else n_pass++;
    consume();
    // reset coinciding with a request wins over the accept
    @(negedge clk);
    input_a = 32'h3F800000; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_vs_accept got in_ready=%0b want 1", in_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/float_to_int_cvt.md
FLOAT_TO_INT_CVT -- requirements
Module: float_to_int_cvt

Interface
REQ-001 SHALL have parameter IW, default 32, meaning integer result width; legal values are 32 and 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: request strobe.
REQ-005 SHALL have port in_ready, output, 1 bit: converter idle and accepting.
REQ-006 SHALL have port input_a, input, 32 bits: IEEE-754 single-precision operand.
REQ-007 SHALL have port rm, input, 3 bits: rounding mode, 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; codes 101-111 are treated as RNE.
REQ-008 SHALL have port is_signed, input, 1 bit: 1 selects a two's-complement result, 0 selects unsigned.
REQ-009 SHALL have port output_z, output, IW bits: integer result.
REQ-010 SHALL have port output_z_stb, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have ports flag_nv and flag_nx, output, 1 bit each: invalid and inexact flags, qualified by output_z_stb.

Function
REQ-013 SHALL implement FSM states IDLE, SPECIAL, SHIFT, ROUND, PUT.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid & in_ready, capturing input_a, rm and is_signed.
REQ-015 SPECIAL SHALL classify the captured operand as follows:
- NaN: result is the maximum positive value, nv=1.
- +Inf: result is the maximum positive value, nv=1.
- -Inf: result is 0x80..0 when signed and 0 when unsigned, nv=1.
- +/-0: result is 0, no flags.
- All these cases go directly to PUT.
REQ-016 Unbiased exponent e >= IW SHALL be treated as overflow (REQ-021) and go to PUT with no SHIFT or ROUND.
REQ-017 For -1 <= e <= IW-1:
- the magnitude register (IW+1 bits) is loaded with {1,frac} left-aligned to bit IW-1;
- the guard and sticky bits are cleared;
- SHIFT shifts right one bit per cycle for exactly IW-1-e cycles;
- on each shift the shifted-out bit becomes guard and the old guard is ORed into sticky.
REQ-018 Subnormals and e < -1 SHALL load magnitude=0, guard=0, sticky=1, and go through SHIFT with zero cycles.
REQ-019 ROUND SHALL add an increment to the magnitude:
- RNE: g&(s|lsb)
- RTZ: 0
- RDN: sign&(g|s)
- RUP: ~sign&(g|s)
- RMM: g
REQ-020 After rounding, SHALL apply the sign; nx = g|s unless nv=1, in which case nx=0.
REQ-021 Overflow SHALL force nv=1, nx=0 and a saturated result:
- signed, positive magnitude > 2^(IW-1)-1: result 2^(IW-1)-1;
- signed, negative magnitude > 2^(IW-1): result 2^(IW-1) as 0x80..0;
- unsigned, magnitude >= 2^IW: result all ones;
- unsigned, negative with nonzero rounded magnitude: result 0.
REQ-022 An unsigned negative input whose rounded magnitude is 0 SHALL give result 0 with nv=0 and nx=g|s.
REQ-023 Latency in cycles after the acceptance edge SHALL be:
- output_z_stb=1 at cycle 2 for SPECIAL-terminated cases;
- output_z_stb=1 at cycle 3+k for all other cases, where k is the SHIFT count.
REQ-024 In PUT, output_z_stb SHALL stay 1, and output_z, flag_nv, flag_nx SHALL be held stable until out_ready=1.
REQ-025 On the PUT cycle with out_ready=1, the FSM SHALL go to IDLE, and output_z_stb SHALL be 0 on the next cycle.
REQ-026 In_valid SHALL be ignored outside IDLE; no request is accepted in the cycle the result is consumed.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE with output_z_stb=0, output_z=0, flag_nv=0, flag_nx=0, in_ready=1 the following cycle.
REQ-028 Rst SHALL take priority over every other event, including a simultaneous accept or out_ready.
REQ-029 After a mid-operation reset, no result of the aborted operation SHALL be presented.

Verification (IW=32)
REQ-030 0x40200000 (2.5), signed -> RNE 0x00000002, RMM 0x00000003, RUP 0x00000003, RTZ 0x00000002; all with nx=1, nv=0.
REQ-031 0xBFC00000 (-1.5) -> signed RNE 0xFFFFFFFE, nx=1; unsigned RTZ 0x00000000, nv=1, nx=0.
REQ-032 0x4F000000 (2^31) -> signed 0x7FFFFFFF, nv=1; unsigned 0x80000000, no flags.
REQ-033 Specials:
- 0x7FC00000 (NaN) -> signed 0x7FFFFFFF, unsigned 0xFFFFFFFF, nv=1.
- 0xFF800000 (-Inf) signed -> 0x80000000, nv=1.
- 0xBE800000 (-0.25) unsigned RTZ -> 0, nx=1, nv=0; signed RDN -> 0xFFFFFFFF, nx=1.
REQ-034 Handshake: 0x3F800000 (1.0) signed -> output_z_stb at cycle 3+31; with out_ready low 5 cycles, stb, data and flags held and in_ready=0; the result is 0x00000001, no flags.
REQ-035 Reset: rst pulsed during SHIFT -> next cycle output_z_stb=0, in_ready=1; a following 0x42F60000 (123.0) request yields 0x0000007B with no flags.
